// File: rtl/udp_rx_pkg.sv
// Shared types and constants for the IPv4/UDP receive parser.
package udp_rx_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_IP_HDR,
        S_UDP_HDR,
        S_PAYLOAD,
        S_DRAIN
    } state_t;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_VER   = 3'd1;
    localparam logic [2:0] ERR_CSUM  = 3'd2;
    localparam logic [2:0] ERR_PROTO = 3'd3;
    localparam logic [2:0] ERR_LEN   = 3'd4;

    localparam logic [15:0] IP_HDR_LEN  = 16'd20;
    localparam logic [15:0] UDP_HDR_LEN = 16'd8;
    localparam logic [7:0]  PROTO_UDP   = 8'h11;

    // Bytes to pull for a packet: never less than a full IP header.
    function automatic logic [15:0] pkt_limit(input logic [15:0] total_len);
        return (total_len > IP_HDR_LEN) ? total_len : IP_HDR_LEN;
    endfunction

endpackage

// File: rtl/ip_csum16.sv
// One's-complement halfword accumulator for the IPv4 header checksum.
module ip_csum16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        acc_en,
    input  logic [15:0] data,
    output logic        csum_ok
);

    logic [15:0] sum;
    logic [16:0] raw;
    logic [15:0] sum_nxt;

    // csum_ok looks at the sum including the halfword presented this cycle.
    always_comb begin
        raw     = {1'b0, sum} + {1'b0, data};
        sum_nxt = raw[15:0] + {15'd0, raw[16]};
        csum_ok = (sum_nxt == 16'hFFFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (acc_en) begin
            sum <= sum_nxt;
        end
    end

endmodule

// File: rtl/udp_rx_parser.sv
// Pops IPv4/UDP datagrams from a byte FIFO, validates headers, publishes
// fields and streams the payload; bad packets are drained and counted.
module udp_rx_parser
    import udp_rx_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  fifo_dout,
    input  logic        fifo_empty,
    output logic        fifo_rd_en,
    output logic [31:0] src_ip,
    output logic [31:0] dst_ip,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [15:0] udp_len,
    output logic        hdr_valid,
    output logic [7:0]  out_data,
    output logic        out_valid,
    output logic        out_last,
    output logic        pkt_err,
    output logic [2:0]  err_code,
    output logic [15:0] pkt_cnt,
    output logic [15:0] err_cnt
);

    state_t      state, state_nxt;
    logic [15:0] issued, rx_idx, total_len, cur_limit;
    logic        len_known, rd_pend;
    logic [7:0]  ver_ihl, proto, prev_byte;
    logic [31:0] src_sh, dst_sh;
    logic [15:0] sport_sh, dport_sh, ulen_sh, ulen_now;
    logic        last_arrival, fresh, fresh_rd, csum_ok, beat;
    logic        hdr_nxt, err_nxt;
    logic [2:0]  code_nxt;

    ip_csum16 u_csum (
        .clk     (clk),
        .rst     (rst),
        .clear   (fresh_rd),
        .acc_en  (rd_pend && (state == S_IP_HDR) && rx_idx[0]),
        .data    ({prev_byte, fifo_dout}),
        .csum_ok (csum_ok)
    );

    // Until total_len is known only bytes 0-3 may be requested; a packet ends
    // when its last byte lands, and the next packet may be requested then.
    always_comb begin
        cur_limit    = len_known ? pkt_limit(total_len) : 16'd4;
        last_arrival = rd_pend && len_known && (rx_idx == cur_limit - 16'd1);
        fresh        = (state == S_IDLE) || last_arrival;
        fifo_rd_en   = !fifo_empty && (fresh || (issued < cur_limit));
        fresh_rd     = fresh && fifo_rd_en;
        ulen_now     = {prev_byte, fifo_dout};
        beat         = rd_pend && (state == S_PAYLOAD);
    end

    always_comb begin
        state_nxt = state;
        hdr_nxt   = 1'b0;
        err_nxt   = 1'b0;
        code_nxt  = ERR_NONE;
        case (state)
            S_IDLE: ;
            S_IP_HDR: begin
                if (rd_pend && (rx_idx == IP_HDR_LEN - 16'd1)) begin
                    if (ver_ihl != 8'h45)                        code_nxt = ERR_VER;
                    else if (!csum_ok)                           code_nxt = ERR_CSUM;
                    else if (proto != PROTO_UDP)                 code_nxt = ERR_PROTO;
                    else if (total_len < IP_HDR_LEN + UDP_HDR_LEN) code_nxt = ERR_LEN;
                    if (code_nxt != ERR_NONE) begin
                        err_nxt   = 1'b1;
                        state_nxt = last_arrival ? S_IDLE : S_DRAIN;
                    end else begin
                        state_nxt = S_UDP_HDR;
                    end
                end
            end
            S_UDP_HDR: begin
                if (rd_pend && (rx_idx == 16'd25) && (ulen_now != total_len - IP_HDR_LEN)) begin
                    err_nxt   = 1'b1;
                    code_nxt  = ERR_LEN;
                    state_nxt = S_DRAIN;
                end
                if (rd_pend && (rx_idx == 16'd27)) begin
                    hdr_nxt   = 1'b1;
                    state_nxt = (ulen_sh > UDP_HDR_LEN) ? S_PAYLOAD : S_IDLE;
                end
            end
            S_PAYLOAD: if (last_arrival) state_nxt = S_IDLE;
            S_DRAIN:   if (last_arrival) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
        if (fresh_rd) state_nxt = S_IP_HDR;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rd_pend   <= 1'b0;
            issued    <= '0;
            rx_idx    <= '0;
            len_known <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= fifo_rd_en;
            if (fresh_rd) begin
                issued    <= 16'd1;
                rx_idx    <= '0;
                len_known <= 1'b0;
            end else begin
                if (fifo_rd_en) issued <= issued + 16'd1;
                if (rd_pend)    rx_idx <= rx_idx + 16'd1;
                if (rd_pend && (state == S_IP_HDR) && (rx_idx == 16'd3)) len_known <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_byte <= '0;
            ver_ihl   <= '0;
            proto     <= '0;
            total_len <= '0;
            src_sh    <= '0;
            dst_sh    <= '0;
            sport_sh  <= '0;
            dport_sh  <= '0;
            ulen_sh   <= '0;
        end else if (rd_pend) begin
            prev_byte <= fifo_dout;
            if (state == S_IP_HDR) begin
                case (rx_idx)
                    16'd0:  ver_ihl          <= fifo_dout;
                    16'd2:  total_len[15:8]  <= fifo_dout;
                    16'd3:  total_len[7:0]   <= fifo_dout;
                    16'd9:  proto            <= fifo_dout;
                    16'd12, 16'd13, 16'd14, 16'd15: src_sh <= {src_sh[23:0], fifo_dout};
                    16'd16, 16'd17, 16'd18, 16'd19: dst_sh <= {dst_sh[23:0], fifo_dout};
                    default: ;
                endcase
            end else if (state == S_UDP_HDR) begin
                case (rx_idx)
                    16'd20, 16'd21: sport_sh <= {sport_sh[7:0], fifo_dout};
                    16'd22, 16'd23: dport_sh <= {dport_sh[7:0], fifo_dout};
                    16'd24, 16'd25: ulen_sh  <= {ulen_sh[7:0], fifo_dout};
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hdr_valid <= 1'b0;
            pkt_err   <= 1'b0;
            err_code  <= '0;
            pkt_cnt   <= '0;
            err_cnt   <= '0;
            src_ip    <= '0;
            dst_ip    <= '0;
            src_port  <= '0;
            dst_port  <= '0;
            udp_len   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            hdr_valid <= hdr_nxt;
            pkt_err   <= err_nxt;
            out_valid <= beat;
            out_last  <= beat && last_arrival;
            if (beat) out_data <= fifo_dout;
            if (err_nxt) begin
                err_code <= code_nxt;
                err_cnt  <= err_cnt + 16'd1;
            end
            if (hdr_nxt) begin
                src_ip   <= src_sh;
                dst_ip   <= dst_sh;
                src_port <= sport_sh;
                dst_port <= dport_sh;
                udp_len  <= ulen_sh;
                pkt_cnt  <= pkt_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_udp_rx_parser.sv
// Directed table-driven bench for udp_rx_parser with a behavioural FIFO.
module tb_udp_rx_parser;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic [7:0]  fifo_dout  = '0;
    logic        fifo_empty = 1'b1;
    logic        fifo_rd_en;
    logic [31:0] src_ip, dst_ip;
    logic [15:0] src_port, dst_port, udp_len;
    logic        hdr_valid;
    logic [7:0]  out_data;
    logic        out_valid, out_last, pkt_err;
    logic [2:0]  err_code;
    logic [15:0] pkt_cnt, err_cnt;

    udp_rx_parser dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .src_ip     (src_ip),
        .dst_ip     (dst_ip),
        .src_port   (src_port),
        .dst_port   (dst_port),
        .udp_len    (udp_len),
        .hdr_valid  (hdr_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_last   (out_last),
        .pkt_err    (pkt_err),
        .err_code   (err_code),
        .pkt_cnt    (pkt_cnt),
        .err_cnt    (err_cnt)
    );

    typedef struct {
        string       name;
        int unsigned p0_idx;
        logic [7:0]  p0_val;
        int unsigned p1_idx;
        logic [7:0]  p1_val;
        logic        stall;
        int unsigned reps;
        logic [2:0]  exp_err;
    } vec_t;

    logic [7:0] ref_pkt [37];
    logic [7:0] q [$];
    logic [7:0] pay_all [$];
    int   rd_ptr = 0;
    int   reads = 0, hdr_total = 0, err_total = 0, last_total = 0, rd_while_empty = 0;
    logic took = 1'b0;
    logic stall_en = 1'b0;
    int   checks = 0, errors = 0;
    int   exp_pkt = 0, exp_errs = 0;
    vec_t vecs [7];

    // FIFO model: a read seen at the falling edge is accepted at the next
    // rising edge and its byte is presented just after that edge.
    always begin
        #5 clk = 1'b1;
        #1;
        if (rst) begin
            rd_ptr = q.size();
        end else if (took) begin
            if (rd_ptr < q.size()) begin
                fifo_dout = q[rd_ptr];
                rd_ptr++;
            end
            reads++;
        end
        fifo_empty = (rd_ptr >= q.size()) || (stall_en && ($urandom_range(0, 2) == 0));
        #4 clk = 1'b0;
        took = fifo_rd_en && !rst;
        if (!rst) begin
            if (fifo_rd_en && fifo_empty) rd_while_empty++;
            if (hdr_valid) hdr_total++;
            if (pkt_err) err_total++;
            if (out_valid) begin
                pay_all.push_back(out_data);
                if (out_last) last_total++;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_hdr_valid"}, 32'(hdr_valid), 32'd0);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_out_data"},  32'(out_data),  32'd0);
        chk({tag, "_out_last"},  32'(out_last),  32'd0);
        chk({tag, "_pkt_err"},   32'(pkt_err),   32'd0);
        chk({tag, "_err_code"},  32'(err_code),  32'd0);
        chk({tag, "_pkt_cnt"},   32'(pkt_cnt),   32'd0);
        chk({tag, "_err_cnt"},   32'(err_cnt),   32'd0);
        chk({tag, "_src_ip"},    src_ip,         32'd0);
        chk({tag, "_dst_ip"},    dst_ip,         32'd0);
        chk({tag, "_ports"},     {src_port, dst_port}, 32'd0);
        chk({tag, "_udp_len"},   32'(udp_len),   32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        chk_zero(tag);
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        exp_pkt  = 0;
        exp_errs = 0;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] pkt [37];
        int  n;
        int  base_reads, base_hdr, base_err, base_last, base_pay;
        logic good;
        good = (v.exp_err == 3'd0);
        for (int i = 0; i < 37; i++) pkt[i] = ref_pkt[i];
        pkt[v.p0_idx] = v.p0_val;
        pkt[v.p1_idx] = v.p1_val;
        base_reads = reads;
        base_hdr   = hdr_total;
        base_err   = err_total;
        base_last  = last_total;
        base_pay   = pay_all.size();
        stall_en   = v.stall;
        for (int unsigned r = 0; r < v.reps; r++)
            for (int i = 0; i < 37; i++) q.push_back(pkt[i]);
        n = 0;
        while ((rd_ptr < q.size()) && (n < 4000)) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        #1;
        stall_en = 1'b0;
        if (good) exp_pkt += int'(v.reps);
        else      exp_errs += 1;
        chk({v.name, "_drained"}, 32'(q.size() - rd_ptr), 32'd0);
        chk({v.name, "_reads"},   32'(reads - base_reads), 32'(37 * v.reps));
        chk({v.name, "_hdr"},     32'(hdr_total - base_hdr), good ? 32'(v.reps) : 32'd0);
        chk({v.name, "_errs"},    32'(err_total - base_err), good ? 32'd0 : 32'd1);
        chk({v.name, "_beats"},   32'(pay_all.size() - base_pay), good ? 32'(9 * v.reps) : 32'd0);
        chk({v.name, "_lasts"},   32'(last_total - base_last), good ? 32'(v.reps) : 32'd0);
        chk({v.name, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_pkt));
        chk({v.name, "_err_cnt"}, 32'(err_cnt), 32'(exp_errs));
        if (!good) begin
            chk({v.name, "_err_code"}, 32'(err_code), 32'(v.exp_err));
        end else begin
            chk({v.name, "_src_ip"},   src_ip, 32'hC0A8020D);
            chk({v.name, "_dst_ip"},   dst_ip, 32'h42816E39);
            chk({v.name, "_src_port"}, 32'(src_port), 32'd36405);
            chk({v.name, "_dst_port"}, 32'(dst_port), 32'd31415);
            chk({v.name, "_udp_len"},  32'(udp_len), 32'd17);
            if (pay_all.size() - base_pay == int'(9 * v.reps)) begin
                for (int k = 0; k < int'(9 * v.reps); k++)
                    chk({v.name, "_payload"}, 32'(pay_all[base_pay + k]), 32'(ref_pkt[28 + (k % 9)]));
            end
        end
        if (rd_ptr < q.size()) do_reset({v.name, "_recover"});
    endtask

    initial begin
        int n, pbase;
        ref_pkt = '{8'h45, 8'h00, 8'h00, 8'h25, 8'hce, 8'h16, 8'h40, 8'h00, 8'h40, 8'h11,
                    8'hf9, 8'h41, 8'hc0, 8'ha8, 8'h02, 8'h0d, 8'h42, 8'h81, 8'h6e, 8'h39,
                    8'h8e, 8'h35, 8'h7a, 8'hb7, 8'h00, 8'h11, 8'hf3, 8'hfd, 8'h52, 8'h55,
                    8'h52, 8'h61, 8'h68, 8'h52, 8'h61, 8'h68, 8'h21};
        vecs[0] = '{"ref",        0,  8'h45, 0,  8'h45, 1'b0, 1, 3'd0};
        vecs[1] = '{"bad_csum",   10, 8'hf8, 10, 8'hf8, 1'b0, 1, 3'd2};
        vecs[2] = '{"bad_proto",  9,  8'h06, 11, 8'h4c, 1'b0, 1, 3'd3};
        vecs[3] = '{"after_bad",  0,  8'h45, 0,  8'h45, 1'b0, 1, 3'd0};
        vecs[4] = '{"bad_ihl",    0,  8'h46, 0,  8'h46, 1'b0, 1, 3'd1};
        vecs[5] = '{"bad_udplen", 25, 8'h12, 25, 8'h12, 1'b0, 1, 3'd4};
        vecs[6] = '{"b2b_stall",  0,  8'h45, 0,  8'h45, 1'b1, 2, 3'd0};

        @(negedge clk);
        #1;
        chk_zero("por");
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        // Reset after the fourth payload beat of a fresh packet.
        pbase = pay_all.size();
        for (int i = 0; i < 37; i++) q.push_back(ref_pkt[i]);
        n = 0;
        while (((pay_all.size() - pbase) < 4) && (n < 2000)) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk("mid_reset_beats_seen", 32'(pay_all.size() - pbase), 32'd4);
        do_reset("mid_reset");
        run_vec(vecs[0]);

        chk("rd_while_empty", 32'(rd_while_empty), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
